// File: rtl/fft_feat_pkg.sv
// Shared constants, FSM state type and accumulator sizing for the fft band-energy feature extractor.
package fft_feat_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_BINS = 16;
    localparam int SQ_W     = 2 * DATA_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        SQUARE,
        OUTPUT
    } state_t;

    // Accumulating 2^avg_shift squares cannot overflow at this width.
    function automatic int acc_w(input int avg_shift);
        return SQ_W + avg_shift;
    endfunction

endpackage

// File: rtl/fft_sq_mac.sv
// Combinational signed square of one fft bin added into that bin's energy accumulator.
module fft_sq_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 33
) (
    input  logic signed [DATA_W-1:0] bin,
    input  logic        [ACC_W-1:0]  acc_in,
    output logic        [ACC_W-1:0]  acc_out
);

    // A square is never negative, so the product's top bit is always 0.
    logic [2*DATA_W-1:0] prod;

    assign prod    = bin * bin;
    assign acc_out = acc_in + ACC_W'(prod);

endmodule

// File: rtl/fft_band_energy.sv
// Snapshots fft bins once per frame, squares them serially, averages over 2^AVG_SHIFT frames
// and streams the 16-word energy vector out over valid/ready.
module fft_band_energy #(
    parameter int DATA_W    = 16,
    parameter int NUM_BINS  = 16,
    parameter int FRAME_LEN = 16,
    parameter int AVG_SHIFT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid_i,
    input  logic [NUM_BINS*DATA_W-1:0] bin_i,
    output logic                       feat_valid_o,
    input  logic                       feat_ready_i,
    output logic [31:0]                feat_data_o,
    output logic [3:0]                 feat_idx_o,
    output logic                       feat_last_o,
    output logic                       overrun_o
);
    import fft_feat_pkg::*;

    localparam int ACC_W = acc_w(AVG_SHIFT);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int FRM_W = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
    localparam logic [3:0] IDX_LAST = 4'(NUM_BINS - 1);

    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           sample_cnt;
    logic [FRM_W-1:0]           frame_cnt;
    logic [3:0]                 bin_idx;
    logic                       overrun;
    logic signed [DATA_W-1:0]   snap [NUM_BINS];
    logic [ACC_W-1:0]           acc  [NUM_BINS];
    logic [ACC_W-1:0]           acc_sum;
    logic [ACC_W-1:0]           acc_avg;

    logic cnt_last, trigger, sq_step, xfer, frame_wrap;

    assign cnt_last   = (sample_cnt == CNT_W'(FRAME_LEN - 1));
    assign trigger    = sample_valid_i && cnt_last;
    assign sq_step    = (state == SQUARE);
    assign xfer       = (state == OUTPUT) && feat_ready_i;
    assign frame_wrap = (frame_cnt == FRM_W'((1 << AVG_SHIFT) - 1));

    fft_sq_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sq_mac (
        .bin     (snap[bin_idx]),
        .acc_in  (acc[bin_idx]),
        .acc_out (acc_sum)
    );

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = SQUARE;
            SQUARE:  if (bin_idx == IDX_LAST) state_nxt = frame_wrap ? OUTPUT : IDLE;
            OUTPUT:  if (xfer && bin_idx == IDX_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            frame_cnt  <= '0;
            bin_idx    <= '0;
            overrun    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (sample_valid_i) sample_cnt <= cnt_last ? '0 : sample_cnt + CNT_W'(1);
            if (trigger && state != IDLE) overrun <= 1'b1;
            // One index walks the bins both while squaring and while streaming out.
            if (sq_step || xfer) bin_idx <= (bin_idx == IDX_LAST) ? '0 : bin_idx + 4'd1;
            if (sq_step && bin_idx == IDX_LAST)
                frame_cnt <= frame_wrap ? '0 : frame_cnt + FRM_W'(1);
        end
    end

    // NOTE: snapshot and accumulators are reset on purpose, so a reset mid-block leaves no
    // stale energy behind; a plain storage array would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BINS; k++) begin
                snap[k] <= '0;
                acc[k]  <= '0;
            end
        end else begin
            if (state == IDLE && trigger) begin
                for (int k = 0; k < NUM_BINS; k++) snap[k] <= bin_i[k*DATA_W +: DATA_W];
            end
            if (sq_step) acc[bin_idx] <= acc_sum;
            else if (xfer) acc[bin_idx] <= '0;
        end
    end

    assign acc_avg      = acc[bin_idx] >> AVG_SHIFT;
    assign feat_valid_o = (state == OUTPUT);
    assign feat_data_o  = 32'(acc_avg);
    assign feat_idx_o   = bin_idx;
    assign feat_last_o  = feat_valid_o && (bin_idx == IDX_LAST);
    assign overrun_o    = overrun;

endmodule

// File: tb/tb_fft_band_energy.sv
// Directed bench: a table of constant-bin scenarios plus hand-written stall and reset sequences.
module tb_fft_band_energy;

    localparam int DATA_W    = 16;
    localparam int NUM_BINS  = 16;
    localparam int FRAME_LEN = 18;
    localparam int AVG_SHIFT = 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       sample_valid;
    logic [NUM_BINS*DATA_W-1:0] bin_bus;
    logic                       feat_valid;
    logic                       feat_ready;
    logic [31:0]                feat_data;
    logic [3:0]                 feat_idx;
    logic                       feat_last;
    logic                       overrun;

    always #5 clk = ~clk;

    fft_band_energy #(
        .DATA_W    (DATA_W),
        .NUM_BINS  (NUM_BINS),
        .FRAME_LEN (FRAME_LEN),
        .AVG_SHIFT (AVG_SHIFT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_valid_i (sample_valid),
        .bin_i          (bin_bus),
        .feat_valid_o   (feat_valid),
        .feat_ready_i   (feat_ready),
        .feat_data_o    (feat_data),
        .feat_idx_o     (feat_idx),
        .feat_last_o    (feat_last),
        .overrun_o      (overrun)
    );

    typedef struct {
        string  name;
        int     period;
        int     bin_val;
        int     sp_idx;
        int     sp_val;
        longint exp_other;
        longint exp_sp;
        int     exp_ovr;
    } vec_t;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int period = 1;
    int ph     = 0;
    int samples = 0;
    int bin_mode = 0;
    int trig_cycle[$];
    int const_bins[NUM_BINS];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drives this cycle's inputs and logs the sample that should trigger a snapshot.
    task automatic drive();
        int frame;
        logic [DATA_W-1:0] v;
        sample_valid = (period != 0) && (ph == 0);
        if (period != 0) ph = (ph + 1) % period;
        frame = samples / FRAME_LEN;
        for (int k = 0; k < NUM_BINS; k++) begin
            v = (bin_mode == 1) ? DATA_W'(10 * (frame + 1) + k) : DATA_W'(const_bins[k]);
            bin_bus[k*DATA_W +: DATA_W] = v;
        end
        if (rst_n && sample_valid) begin
            if (samples % FRAME_LEN == FRAME_LEN - 1) trig_cycle.push_back(cyc);
            samples++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        check({name, "_rst_valid"}, feat_valid, 0);
        check({name, "_rst_data"}, feat_data, 0);
        check({name, "_rst_idx"}, feat_idx, 0);
        check({name, "_rst_last"}, feat_last, 0);
        check({name, "_rst_overrun"}, overrun, 0);
        repeat (3) step();
        rst_n   = 1'b1;
        ph      = 0;
        samples = 0;
        trig_cycle.delete();
        drive();
    endtask

    // Valid must first rise exactly 17 cycles after the trigger that completes the block.
    task automatic wait_valid(input string name, input int trig_idx);
        int budget = 2000;
        longint lat;
        while (!feat_valid && budget > 0) begin
            step();
            budget--;
        end
        check({name, "_valid_seen"}, feat_valid, 1);
        lat = (trig_cycle.size() > trig_idx) ? longint'(cyc - trig_cycle[trig_idx]) : -1;
        check({name, "_latency"}, lat, 17);
    endtask

    task automatic collect(input string name, output longint w[NUM_BINS]);
        int got = 0;
        int budget = 3000;
        for (int k = 0; k < NUM_BINS; k++) w[k] = -1;
        while (got < NUM_BINS && budget > 0) begin
            if (feat_valid && feat_ready) begin
                check({name, "_idx"}, feat_idx, got);
                check({name, "_last"}, feat_last, (got == NUM_BINS - 1) ? 1 : 0);
                w[got] = feat_data;
                got++;
            end
            step();
            budget--;
        end
        check({name, "_words"}, got, NUM_BINS);
        check({name, "_valid_drop"}, feat_valid, 0);
    endtask

    function automatic longint exp_ramp(input int k, input int f0);
        longint s = 0;
        for (int f = f0; f < f0 + 4; f++) s += longint'((10 * (f + 1) + k) * (10 * (f + 1) + k));
        return s >> AVG_SHIFT;
    endfunction

    vec_t   vecs[4];
    longint words[NUM_BINS];

    initial begin
        int bad;
        int budget;
        logic [31:0] held;

        vecs[0] = '{"all100",   1, 100,  -1, 0,      10000, 0,          1};
        vecs[1] = '{"bin3_min", 1, 0,     3, -32768, 0,     1073741824, 1};
        vecs[2] = '{"every3rd", 3, 100,  -1, 0,      10000, 0,          0};
        vecs[3] = '{"mixed",    1, -7,    5, 32767,  49,    1073676289, 1};

        rst_n = 1'b0;
        feat_ready = 1'b1;
        for (int k = 0; k < NUM_BINS; k++) const_bins[k] = 100;
        drive();
        repeat (3) step();
        rst_n = 1'b1;
        drive();
        // Leave the stream running mid-frame so the first table reset lands mid-stream.
        repeat (30) step();

        for (int i = 0; i < 4; i++) begin
            period = vecs[i].period;
            bin_mode = 0;
            for (int k = 0; k < NUM_BINS; k++)
                const_bins[k] = (k == vecs[i].sp_idx) ? vecs[i].sp_val : vecs[i].bin_val;
            feat_ready = 1'b1;
            do_reset(vecs[i].name);
            wait_valid(vecs[i].name, 3);
            check({vecs[i].name, "_ovr_before"}, overrun, 0);
            collect(vecs[i].name, words);
            for (int k = 0; k < NUM_BINS; k++)
                check($sformatf("%s_word%0d", vecs[i].name, k), words[k],
                      (k == vecs[i].sp_idx) ? vecs[i].exp_sp : vecs[i].exp_other);
            check({vecs[i].name, "_ovr_after"}, overrun, vecs[i].exp_ovr);
        end

        // Stall word 0 for 40 cycles: frames 4..7 are dropped (frame 7 triggers on the
        // final transfer), so the second vector averages frames 8..11.
        period = 1;
        bin_mode = 1;
        feat_ready = 1'b0;
        do_reset("stall");
        wait_valid("stall_v1", 3);
        held = feat_data;
        check("stall_word0_value", held, exp_ramp(0, 0));
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (!(feat_valid && feat_idx == 4'd0 && feat_data == held)) bad++;
            step();
        end
        check("stall_hold_stable", bad, 0);
        check("stall_overrun", overrun, 1);
        feat_ready = 1'b1;
        collect("stall_v1", words);
        for (int k = 0; k < NUM_BINS; k++)
            check($sformatf("stall_v1_word%0d", k), words[k], exp_ramp(k, 0));
        wait_valid("stall_v2", 11);
        collect("stall_v2", words);
        for (int k = 0; k < NUM_BINS; k++)
            check($sformatf("stall_v2_word%0d", k), words[k], exp_ramp(k, 8));

        // Reset during the squaring of frame 2, then four fresh frames of bins = 5.
        bin_mode = 0;
        for (int k = 0; k < NUM_BINS; k++) const_bins[k] = 100;
        do_reset("midsq_pre");
        budget = 500;
        while (trig_cycle.size() < 3 && budget > 0) begin
            step();
            budget--;
        end
        check("midsq_frame2_trigger", trig_cycle.size(), 3);
        repeat (5) step();
        check("midsq_no_valid_yet", feat_valid, 0);
        for (int k = 0; k < NUM_BINS; k++) const_bins[k] = 5;
        do_reset("midsq");
        wait_valid("midsq", 3);
        collect("midsq", words);
        for (int k = 0; k < NUM_BINS; k++)
            check($sformatf("midsq_word%0d", k), words[k], 25);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
